alu_hier: RTL and testbench
===========================

Name: alu_hier

Overview:
- 16-bit combinational ALU for the processor execute stage.
- Optionally inverts either operand, then performs one of 8 operations:
  - rotate left, shift left, rotate right, shift right logical
  - add with carry-in, OR, XOR, AND
- Reports signed/unsigned overflow and a zero flag.
- A single synchronous-reset flop blanks all outputs while the block is in reset.

Parameters:
- OPERAND_WIDTH, 16, width of InA, InB and Out. Shift amount width is log2(OPERAND_WIDTH), i.e. 4 bits.
- NUM_OPERATIONS, 3, width of Oper.

Ports:
- clk  input  1  system clock; one clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- InA  input  OPERAND_WIDTH  operand A before optional inversion.
- InB  input  OPERAND_WIDTH  operand B before optional inversion.
- Cin  input  1  carry-in; used by the add only.
- Oper  input  NUM_OPERATIONS  operation select.
- invA  input  1  when 1, operand A = ~InA.
- invB  input  1  when 1, operand B = ~InB.
- sign  input  1  1 = signed overflow rule, 0 = unsigned.
- Out  output  OPERAND_WIDTH  result.
- Ofl  output  1  overflow flag.
- Zero  output  1  result-is-zero flag.

Behaviour:
- Operand inversion: A = invA ? ~InA : InA; B = invB ? ~InB : InB. Inversion applies before every operation, including shifts and logic.
- Shift amount is B[3:0] (after inversion); upper bits of B are ignored.
- Oper decode:
  - 000: rotate A left by B[3:0].
  - 001: shift A left logical, zero fill.
  - 010: rotate A right.
  - 011: shift A right logical, zero fill.
  - 100: Out = (A + B + Cin) mod 2^16.
  - 101: A | B.
  - 110: A ^ B.
  - 111: A & B.
- Shifter: 4-stage barrel (shift by 1/2/4/8); a shift/rotate amount of 0 passes A unchanged.
- Adder: 16-bit ripple or carry-lookahead built from 1-bit full adders. Expose carry-out (c16) and carry into bit 15 (c15).
- Ofl:
  - Add with sign=1: Ofl = c15 ^ c16 (signed overflow; equivalently Sum[15]^A[15]^B[15]^c16).
  - Add with sign=0: Ofl = c16.
  - All non-add ops: Ofl = 0.
- Zero = (Out == 0) for every op, not just add.
- Cin and sign are ignored for non-add ops.
- Timing:
  - Datapath is purely combinational, zero cycles of latency.
  - Outputs settle within half a clock period of an input change.
  - Inputs change at posedge and are checked at negedge.
- Reset:
  - Internal flop rst_q is set on any posedge where rst_n=0, and cleared on a posedge where rst_n=1.
  - While rst_q=1: Out=0x0000, Ofl=0, Zero=0.
  - After the first posedge with rst_n=1, outputs track the inputs combinationally.
  - Asserting reset mid-operation blanks outputs from the next posedge onward.
  - Before the first posedge, outputs are undefined.
- No other state, handshake, or X-propagation beyond the inputs. Every Oper code is legal.

Test Plan:
- Rotates and shifts:
  - InA=0x8001, InB=0x0004, Oper=000 -> Out=0x0018.
  - Oper=010, InA=0x0001, InB=0x0001 -> Out=0x8000.
  - Oper=011, InA=0x8000, InB=0x000F -> 0x0001.
  - Oper=001, InA=0x0001, InB=0x0013 (uses B[3:0]=3) -> 0x0008.
  - All of these give Ofl=0.
- Unsigned carry: Oper=100, InA=0xFFFF, InB=0x0001, Cin=0, sign=0 -> Out=0x0000, Zero=1, Ofl=1.
- Signed overflow: Oper=100, InA=0x7FFF, InB=0x0001, Cin=0:
  - sign=1 -> Out=0x8000, Ofl=1, Zero=0.
  - sign=0 -> Ofl=0.
- Subtract via inversion: Oper=100, InA=0x0005, InB=0x0003, invB=1, Cin=1, sign=1 -> Out=0x0002, Ofl=0, Zero=0. With sign=0 the same inputs give Ofl=1 (carry-out).
- Logic with inversion: InA=0xF0F0, InB=0xFF00, invA=1 (A=0x0F0F):
  - OR -> 0xFF0F.
  - XOR -> 0xF00F.
  - AND -> 0x0F00.
  - InA=0x00FF, InB=0xFF00, AND, no inversion -> 0x0000, Zero=1.
- Reset: hold rst_n=0 across a posedge with add inputs 0x1234+0x1111 -> Out=0x0000, Ofl=0, Zero=0. Release rst_n, and after the next posedge -> Out=0x2345. Then run 1000 random-input cycles against a reference model checked at negedge.

Source files
------------

// File: rtl/alu_hier.sv
// alu_hier: 16-bit execute-stage ALU (optional operand inversion, barrel shifter, ripple adder, logic ops, flags).
// Zero-cycle combinational datapath; one synchronous reset flop blanks the outputs; no handshake, never stalls.

module alu_hier_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module alu_hier_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         c_msb,
  output logic         c_out
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    alu_hier_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // c_msb is the carry into the sign bit, needed for the signed overflow rule
  assign c_msb = c[W-1];
  assign c_out = c[W];
endmodule

module alu_hier_shifter #(
  parameter int W  = 16,
  parameter int SW = 4
) (
  input  logic [W-1:0]  a,
  input  logic [SW-1:0] amt,
  input  logic [1:0]    mode,
  output logic [W-1:0]  y
);
  // mode: 00 rotate left, 01 shift left, 10 rotate right, 11 shift right logical
  logic [SW:0][W-1:0] stg;

  assign stg[0] = a;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [W-1:0] rot_l;
    logic [W-1:0] rot_r;
    logic [W-1:0] sh_l;
    logic [W-1:0] sh_r;
    logic [W-1:0] nxt;

    assign rot_l = {stg[k][W-SH-1:0], stg[k][W-1:W-SH]};
    assign rot_r = {stg[k][SH-1:0], stg[k][W-1:SH]};
    assign sh_l  = {stg[k][W-SH-1:0], {SH{1'b0}}};
    assign sh_r  = {{SH{1'b0}}, stg[k][W-1:SH]};

    assign nxt = mode[1] ? (mode[0] ? sh_r : rot_r)
                         : (mode[0] ? sh_l : rot_l);

    assign stg[k+1] = amt[k] ? nxt : stg[k];
  end

  assign y = stg[SW];
endmodule

module alu_hier #(
  parameter int OPERAND_WIDTH  = 16,
  parameter int NUM_OPERATIONS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OPERAND_WIDTH-1:0]  InA,
  input  logic [OPERAND_WIDTH-1:0]  InB,
  input  logic                      Cin,
  input  logic [NUM_OPERATIONS-1:0] Oper,
  input  logic                      invA,
  input  logic                      invB,
  input  logic                      sign,
  output logic [OPERAND_WIDTH-1:0]  Out,
  output logic                      Ofl,
  output logic                      Zero
);
  localparam int W  = OPERAND_WIDTH;
  localparam int SW = $clog2(OPERAND_WIDTH);

  localparam logic [NUM_OPERATIONS-1:0] OP_ADD = 3'b100;
  localparam logic [NUM_OPERATIONS-1:0] OP_OR  = 3'b101;
  localparam logic [NUM_OPERATIONS-1:0] OP_XOR = 3'b110;
  localparam logic [NUM_OPERATIONS-1:0] OP_AND = 3'b111;

  logic [W-1:0] a_op;
  logic [W-1:0] b_op;
  logic [W-1:0] shift_res;
  logic [W-1:0] sum;
  logic         c15;
  logic         c16;
  logic [W-1:0] res;
  logic         ofl_raw;
  logic         rst_d;
  logic         rst_q;

  assign a_op = invA ? ~InA : InA;
  assign b_op = invB ? ~InB : InB;

  alu_hier_shifter #(
    .W  (W),
    .SW (SW)
  ) u_shifter (
    .a    (a_op),
    .amt  (b_op[SW-1:0]),
    .mode (Oper[1:0]),
    .y    (shift_res)
  );

  alu_hier_adder #(
    .W (W)
  ) u_adder (
    .a     (a_op),
    .b     (b_op),
    .ci    (Cin),
    .sum   (sum),
    .c_msb (c15),
    .c_out (c16)
  );

  always_comb begin
    res     = shift_res;
    ofl_raw = 1'b0;
    case (Oper)
      OP_ADD: begin
        res     = sum;
        ofl_raw = sign ? (c15 ^ c16) : c16;
      end
      OP_OR:   res = a_op | b_op;
      OP_XOR:  res = a_op ^ b_op;
      OP_AND:  res = a_op & b_op;
      default: res = shift_res;
    endcase
  end

  always_comb rst_d = ~rst_n;

  always_ff @(posedge clk) begin
    rst_q <= rst_d;
  end

  // Zero is forced low during reset, not derived from the blanked Out
  assign Out  = rst_q ? '0   : res;
  assign Ofl  = rst_q ? 1'b0 : ofl_raw;
  assign Zero = rst_q ? 1'b0 : (res == '0);
endmodule

// File: tb/tb_alu_hier.sv
// Bench for alu_hier: vector table, reset sequences and random traffic, all through an expected-result queue.
module tb_alu_hier;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] InA, InB;
  logic        Cin;
  logic [2:0]  Oper;
  logic        invA, invB, sign;
  logic [15:0] Out;
  logic        Ofl, Zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [2:0]  oper;
    logic [15:0] ina;
    logic [15:0] inb;
    logic        cin;
    logic        inva;
    logic        invb;
    logic        sgn;
    logic [15:0] e_out;
    logic        e_ofl;
    logic        e_zero;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic        ofl;
    logic        zero;
  } exp_t;

  exp_t sb[$];

  alu_hier dut (
    .clk  (clk),
    .rst_n(rst_n),
    .InA  (InA),
    .InB  (InB),
    .Cin  (Cin),
    .Oper (Oper),
    .invA (invA),
    .invB (invB),
    .sign (sign),
    .Out  (Out),
    .Ofl  (Ofl),
    .Zero (Zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input string nm, input logic [2:0] op, input logic [15:0] ia,
                                 input logic [15:0] ib, input logic ci, input logic ia_n,
                                 input logic ib_n, input logic sg);
    exp_t        e;
    logic [15:0] a, b, r;
    logic [31:0] aa, t;
    logic [16:0] s17;
    logic [3:0]  sh;
    a  = ia_n ? ~ia : ia;
    b  = ib_n ? ~ib : ib;
    sh = b[3:0];
    aa = {a, a};
    e.ofl = 1'b0;
    case (op)
      3'b000: begin t = aa << sh; r = t[31:16]; end
      3'b001: r = a << sh;
      3'b010: begin t = aa >> sh; r = t[15:0]; end
      3'b011: r = a >> sh;
      3'b100: begin
        s17   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        r     = s17[15:0];
        e.ofl = sg ? ((a[15] == b[15]) && (r[15] != a[15])) : s17[16];
      end
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: r = a & b;
    endcase
    e.name = nm;
    e.out  = r;
    e.zero = (r == 16'h0000);
    return e;
  endfunction

  task automatic set_inputs(input logic [2:0] op, input logic [15:0] ia, input logic [15:0] ib,
                            input logic ci, input logic ia_n, input logic ib_n, input logic sg);
    Oper = op; InA = ia; InB = ib; Cin = ci; invA = ia_n; invB = ib_n; sign = sg;
  endtask

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Pops the oldest expectation and compares it against the live outputs
  task automatic check_next();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".out"},  Out,          e.out);
    cmp({e.name, ".ofl"},  {15'd0, Ofl}, {15'd0, e.ofl});
    cmp({e.name, ".zero"}, {15'd0, Zero}, {15'd0, e.zero});
  endtask

  task automatic push_blank(input string nm);
    exp_t e;
    e.name = nm; e.out = 16'h0000; e.ofl = 1'b0; e.zero = 1'b0;
    sb.push_back(e);
  endtask

  vec_t vt[$];

  initial begin
    vt = '{
      '{"rol_8001_4",   3'b000, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0018, 1'b0, 1'b0},
      '{"ror_0001_1",   3'b010, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0},
      '{"shr_8000_15",  3'b011, 16'h8000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0},
      '{"shl_b13",      3'b001, 16'h0001, 16'h0013, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0},
      '{"rol_by0",      3'b000, 16'hABCD, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0, 1'b0},
      '{"shr_inv",      3'b011, 16'h7FFF, 16'hFFF0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0},
      '{"add_ucarry",   3'b100, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1},
      '{"add_sovf",     3'b100, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0},
      '{"add_nosovf_u", 3'b100, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0},
      '{"sub_signed",   3'b100, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 1'b0},
      '{"sub_unsigned", 3'b100, 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0},
      '{"or_invA",      3'b101, 16'hF0F0, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFF0F, 1'b0, 1'b0},
      '{"xor_invA",     3'b110, 16'hF0F0, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 16'hF00F, 1'b0, 1'b0},
      '{"and_invA",     3'b111, 16'hF0F0, 16'hFF00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0F00, 1'b0, 1'b0},
      '{"and_zero",     3'b111, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1},
      '{"or_cin_sign",  3'b101, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b0}
    };

    // Reset held across a posedge blanks the outputs
    rst_n = 1'b0;
    set_inputs(3'b100, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    push_blank("rst_hold");
    @(negedge clk);
    check_next();

    @(posedge clk); #1;
    rst_n = 1'b1;
    push_blank("rst_release_pre_edge");
    @(negedge clk);
    check_next();
    sb.push_back(model("rst_release", 3'b100, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    cmp("rst_release_sum", Out, 16'h2345);
    check_next();

    foreach (vt[i]) begin
      exp_t e;
      @(posedge clk); #1;
      set_inputs(vt[i].oper, vt[i].ina, vt[i].inb, vt[i].cin, vt[i].inva, vt[i].invb, vt[i].sgn);
      e.name = vt[i].name; e.out = vt[i].e_out; e.ofl = vt[i].e_ofl; e.zero = vt[i].e_zero;
      sb.push_back(e);
      @(negedge clk);
      check_next();
    end

    for (int n = 0; n < 1000; n++) begin
      logic [2:0]  op;
      logic [15:0] ia, ib;
      logic        ci, na, nb, sg;
      op = 3'($urandom_range(7));
      ia = 16'($urandom);
      ib = 16'($urandom);
      if (n % 16 == 0) ib = ~ia;
      ci = 1'($urandom); na = 1'($urandom); nb = 1'($urandom); sg = 1'($urandom);
      @(posedge clk); #1;
      set_inputs(op, ia, ib, ci, na, nb, sg);
      sb.push_back(model($sformatf("rand%0d", n), op, ia, ib, ci, na, nb, sg));
      @(negedge clk);
      check_next();
    end

    // Reset asserted mid-operation: live until the next posedge, blank after
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_inputs(3'b110, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(model("midrst_live", 3'b110, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_next();
    push_blank("midrst_blank");
    @(negedge clk);
    check_next();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_inputs(3'b100, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    sb.push_back(model("midrst_recover", 3'b100, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1));
    @(negedge clk);
    check_next();

    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
